// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard and flush controller: load-use and HiLo stalls,
// branch/jump flushes, a mult/div busy counter and a stall-cycle counter.
module hazard_flush_ctrl #(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  IDRs,
    input  logic [4:0]  IDRt,
    input  logic        IDUsesRt,
    input  logic        IDMulDiv,
    input  logic        IDReadsHiLo,
    input  logic        IDJump,
    input  logic        EXMemRead,
    input  logic [4:0]  EXRt,
    input  logic        EXBranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        MulDivBusy,
    output logic [15:0] StallCycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [15:0] r_stall_cycles;

    logic w_lu;
    logic w_hl;
    logic w_stall;
    logic w_issue;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign w_lu = EXMemRead && (EXRt != 5'd0) &&
                  ((EXRt == IDRs) || (IDUsesRt && (EXRt == IDRt)));
    assign w_hl    = (r_cnt != 4'd0) && (IDMulDiv || IDReadsHiLo);
    assign w_stall = (w_lu || w_hl) && !EXBranchTaken;
    assign w_issue = IDMulDiv && !w_stall && !EXBranchTaken;

    assign MulDivBusy  = (r_cnt != 4'd0);
    assign StallCycles = r_stall_cycles;

    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        if (Rst) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (EXBranchTaken) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (w_stall) begin
            // Stall beats a jump in ID; the jump flush follows once the stall clears.
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end else if (IDJump) begin
            IFIDFlush = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_cnt_nxt   = 4'(MULDIV_LAT);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // A taken branch does not stop a unit that is already running.
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!PCWrite && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

endmodule
